multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the retired-instruction counter.
REQ-002 Port: clock  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: Opcode  in  7  opcode field of the instruction register; valid in DECODE and later.
REQ-005 Port: Funct3  in  3  funct3 field of the instruction register.
REQ-006 Port: MemReady  in  1  memory completes the current request this cycle.
REQ-007 Port: Halt  in  1  while high, no new fetch is issued.
REQ-008 Port: MemReq  out  1  memory request valid.
REQ-009 Port: MemRead / MemWrite  out  1 each  access type qualifying MemReq.
REQ-010 Port: IRWrite / PCWrite  out  1 each  instruction-register load / PC load strobes.
REQ-011 Port: WriteEnable  out  1  register-file write strobe.
REQ-012 Port: ALU  out  2  00 ADD, 01 op from Funct3, 10 pass operand B.
REQ-013 Port: Op1  out  2  00 rs1, 01 PC, 10 zero.
REQ-014 Port: Op2  out  3  000 rs2, 001 imm-I, 010 imm-S, 011 imm-U, 100 constant 4.
REQ-015 Port: Trap  out  1  illegal instruction seen; sticky.
REQ-016 Port: Retired  out  CNT_W  count of completed instructions.
REQ-017 Port: State  out  3  current FSM state, debug only.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP.
- Outputs are registered or decoded from the current state and latched instruction class only.
REQ-019 In FETCH with Halt=0, the block SHALL drive MemReq=1, MemRead=1, Op1=01, Op2=100 and ALU=00.
REQ-020 In FETCH with Halt=1, the block SHALL drive MemReq=0 and stay in FETCH.
- Halt is sampled only when no request is outstanding.
REQ-021 MemReq, once asserted, SHALL stay high with stable MemRead/MemWrite until a cycle with MemReady=1.
- A Halt rise mid-request is ignored until the request completes.
REQ-022 In a FETCH cycle with MemReq=1 and MemReady=1, the block SHALL pulse IRWrite=1 and PCWrite=1 and go to DECODE.
REQ-023 In DECODE, the block SHALL latch the instruction class from Opcode/Funct3.
- Legal: R 0110011, LUI 0110111, I 0010011 (any Funct3), LW 0000011 with Funct3=010, SW 0100011 with Funct3=010.
- Legal → EXEC; anything else → TRAP.
REQ-024 In EXEC, the block SHALL drive the per-class operand and ALU selects, then move to the next state:

| Class | Op1 | Op2 | ALU | Next |
|---|---|---|---|---|
| R | 00 | 000 | 01 | WB |
| I | 00 | 001 | 01 | WB |
| LUI | 10 | 011 | 10 | WB |
| LW | 00 | 001 | 00 | MEM |
| SW | 00 | 010 | 00 | MEM |

REQ-025 In MEM, the block SHALL drive MemReq=1 with MemRead=1 for LW or MemWrite=1 for SW, and hold until MemReady.
- LW → WB.
- SW retires → FETCH.
REQ-026 In WB, the block SHALL pulse WriteEnable=1 for exactly one cycle, retire, and go to FETCH.
REQ-027 Retire SHALL increment Retired by 1, modulo 2^CNT_W; all-ones wraps to zero.
REQ-028 In TRAP, the block SHALL hold Trap=1 and all strobes/MemReq at 0 until reset_n is asserted.
REQ-029 Latency with zero-wait memory SHALL be:
- R, I, LUI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- Each MemReady-low cycle adds 1 cycle.
REQ-030 WriteEnable and MemWrite SHALL never be high in the same cycle.
REQ-031 IRWrite SHALL never be high outside FETCH.

Reset
REQ-032 reset_n=0 SHALL immediately, independent of clock, force:
- State=FETCH.
- Retired=0, Trap=0.
- MemReq, MemRead, MemWrite, IRWrite, PCWrite, WriteEnable=0.
- ALU=00, Op1=00, Op2=000.
REQ-033 A reset asserted mid-request SHALL abandon the request; MemReq is 0 during reset.
REQ-034 On the first clock edge after reset_n rises, with Halt=0, the block SHALL enter FETCH and drive MemReq=1 that cycle.

Structure
REQ-035 A shared package SHALL hold:
- the opcode constants and the state encoding;
- the instruction-class enumeration;
- the ALU, Op1 and Op2 select encodings.
REQ-036 The class decode SHALL be a combinational sub-module mc_decode.
- Inputs: Opcode, Funct3. Outputs: class, legal.
- The FSM and the counter stay in multicycle_ctrl.

Verification
REQ-037 R-type (0110011/000) with MemReady tied 1 → FETCH,DECODE,EXEC,WB; WriteEnable=1 in cycle 4; EXEC shows Op2=000, ALU=01; Retired 0→1.
REQ-038 LW (0000011/010) with MemReady low for 2 MEM cycles → MemReq/MemRead held 3 cycles; WB follows; total 7 cycles; WriteEnable pulses once.
REQ-039 SW (0100011/010) → MEM with MemWrite=1, Op2=010; no WriteEnable; back to FETCH after 4 cycles; Retired increments.
REQ-040 Illegal Opcode 1111111, and LW with Funct3=000 → TRAP; Trap=1, MemReq stays 0 for 10 cycles; reset_n pulse clears it.
REQ-041 Halt=1 at reset release → MemReq=0 for 5 cycles; Halt→0 → MemReq=1 the next cycle.
REQ-042 Edge cases:
- Retired preset to 255 (CNT_W=8), one more retire → Retired=0.
- reset_n low in mid-MEM → all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// instruction classes and datapath select values.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LUI = 3'd2,
    CLS_LW  = 3'd3,
    CLS_SW  = 3'd4
  } iclass_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_FUNCT = 2'b01,
    ALU_PASSB = 2'b10
  } alu_sel_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'b00,
    OP1_PC   = 2'b01,
    OP1_ZERO = 2'b10
  } op1_sel_t;

  typedef enum logic [2:0] {
    OP2_RS2  = 3'b000,
    OP2_IMMI = 3'b001,
    OP2_IMMS = 3'b010,
    OP2_IMMU = 3'b011,
    OP2_FOUR = 3'b100
  } op2_sel_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decode from the opcode and funct3 fields.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CLS_R;
    legal  = 1'b0;
    case (Opcode)
      OPC_R: begin
        iclass = CLS_R;
        legal  = 1'b1;
      end
      OPC_I: begin
        iclass = CLS_I;
        legal  = 1'b1;
      end
      OPC_LUI: begin
        iclass = CLS_LUI;
        legal  = 1'b1;
      end
      OPC_LOAD: begin
        iclass = CLS_LW;
        legal  = (Funct3 == F3_WORD);
      end
      OPC_STORE: begin
        iclass = CLS_SW;
        legal  = (Funct3 == F3_WORD);
      end
      default: begin
        iclass = CLS_R;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXEC/MEM/WB
// with a sticky TRAP state and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       Funct3,
  input  logic             MemReady,
  input  logic             Halt,
  output logic             MemReq,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             WriteEnable,
  output logic [1:0]       ALU,
  output logic [1:0]       Op1,
  output logic [2:0]       Op2,
  output logic             Trap,
  output logic [CNT_W-1:0] Retired,
  output logic [2:0]       State
);

  state_t           state_q, state_d;
  iclass_t          cls_q, dec_cls;
  logic             dec_legal;
  logic             fetch_req_q, fetch_req_d;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  mc_decode u_decode (
    .Opcode (Opcode),
    .Funct3 (Funct3),
    .iclass (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      fetch_req_q <= 1'b0;
      cls_q       <= CLS_R;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_req_q <= fetch_req_d;
      if (state_q == ST_DECODE) cls_q <= dec_cls;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // fetch_req_q marks an outstanding fetch; Halt is only sampled while it is
  // clear, so a request in flight always completes once issued.
  always_comb begin
    state_d     = state_q;
    fetch_req_d = fetch_req_q;
    retire      = 1'b0;
    MemReq      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    WriteEnable = 1'b0;
    ALU         = ALU_ADD;
    Op1         = OP1_RS1;
    Op2         = OP2_RS2;
    Trap        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (fetch_req_q) begin
          MemReq  = 1'b1;
          MemRead = 1'b1;
          Op1     = OP1_PC;
          Op2     = OP2_FOUR;
          ALU     = ALU_ADD;
          if (MemReady) begin
            IRWrite     = 1'b1;
            PCWrite     = 1'b1;
            fetch_req_d = 1'b0;
            state_d     = ST_DECODE;
          end
        end else begin
          fetch_req_d = !Halt;
        end
      end
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            Op1 = OP1_RS1; Op2 = OP2_RS2;  ALU = ALU_FUNCT; state_d = ST_WB;
          end
          CLS_I: begin
            Op1 = OP1_RS1; Op2 = OP2_IMMI; ALU = ALU_FUNCT; state_d = ST_WB;
          end
          CLS_LUI: begin
            Op1 = OP1_ZERO; Op2 = OP2_IMMU; ALU = ALU_PASSB; state_d = ST_WB;
          end
          CLS_LW: begin
            Op1 = OP1_RS1; Op2 = OP2_IMMI; ALU = ALU_ADD; state_d = ST_MEM;
          end
          CLS_SW: begin
            Op1 = OP1_RS1; Op2 = OP2_IMMS; ALU = ALU_ADD; state_d = ST_MEM;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        MemReq   = 1'b1;
        MemRead  = (cls_q == CLS_LW);
        MemWrite = (cls_q == CLS_SW);
        if (MemReady) begin
          if (cls_q == CLS_SW) begin
            retire      = 1'b1;
            state_d     = ST_FETCH;
            fetch_req_d = !Halt;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        WriteEnable = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
        fetch_req_d = !Halt;
      end
      ST_TRAP: Trap = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign Retired = retired_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// legal instructions with random memory wait states, checked per cycle.
module tb_multicycle_ctrl;

  logic       clock;
  logic       reset_n;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       MemReady;
  logic       Halt;
  logic       MemReq, MemRead, MemWrite, IRWrite, PCWrite, WriteEnable;
  logic [1:0] ALU, Op1;
  logic [2:0] Op2;
  logic       Trap;
  logic [7:0] Retired;
  logic [2:0] State;

  multicycle_ctrl #(.CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .Opcode      (Opcode),
    .Funct3      (Funct3),
    .MemReady    (MemReady),
    .Halt        (Halt),
    .MemReq      (MemReq),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .WriteEnable (WriteEnable),
    .ALU         (ALU),
    .Op1         (Op1),
    .Op2         (Op2),
    .Trap        (Trap),
    .Retired     (Retired),
    .State       (State)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       req, rd, wr, irw, pcw, we;
    logic [1:0] alu, op1;
    logic [2:0] op2;
    logic       trap;
  } vec_t;

  vec_t       obs;
  logic [7:0] exp_ret;
  int         n_cmp = 0;
  int         n_bad = 0;

  assign obs = {State, MemReq, MemRead, MemWrite, IRWrite, PCWrite, WriteEnable,
                ALU, Op1, Op2, Trap};

  // Reference class: 0 R, 1 I, 2 LUI, 3 LW, 4 SW, -1 illegal
  function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'b0110011) return 0;
    if (op == 7'b0010011) return 1;
    if (op == 7'b0110111) return 2;
    if (op == 7'b0000011 && f3 == 3'b010) return 3;
    if (op == 7'b0100011 && f3 == 3'b010) return 4;
    return -1;
  endfunction

  function automatic vec_t v_idle();
    vec_t v = '0;
    return v;
  endfunction

  function automatic vec_t v_fetch(input logic done);
    vec_t v = '0;
    v.req = 1'b1; v.rd = 1'b1; v.op1 = 2'b01; v.op2 = 3'b100;
    v.irw = done; v.pcw = done;
    return v;
  endfunction

  function automatic vec_t v_decode();
    vec_t v = '0;
    v.st = 3'd1;
    return v;
  endfunction

  function automatic vec_t v_exec(input int c);
    vec_t v = '0;
    v.st = 3'd2;
    case (c)
      0: begin v.op1 = 2'b00; v.op2 = 3'b000; v.alu = 2'b01; end
      1: begin v.op1 = 2'b00; v.op2 = 3'b001; v.alu = 2'b01; end
      2: begin v.op1 = 2'b10; v.op2 = 3'b011; v.alu = 2'b10; end
      3: begin v.op1 = 2'b00; v.op2 = 3'b001; v.alu = 2'b00; end
      default: begin v.op1 = 2'b00; v.op2 = 3'b010; v.alu = 2'b00; end
    endcase
    return v;
  endfunction

  function automatic vec_t v_mem(input int c);
    vec_t v = '0;
    v.st = 3'd3; v.req = 1'b1; v.rd = (c == 3); v.wr = (c == 4);
    return v;
  endfunction

  function automatic vec_t v_wb();
    vec_t v = '0;
    v.st = 3'd4; v.we = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_trap();
    vec_t v = '0;
    v.st = 3'd5; v.trap = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    n_cmp++;
    assert (Retired === exp_ret) else begin
      n_bad++;
      $error("FAIL %s/retired: observed %0d expected %0d", tag, Retired, exp_ret);
    end
  endtask

  // Called at posedge+1: drive MemReady, check mid-cycle, advance one clock.
  task automatic cyc(input string tag, input vec_t e, input logic rdy);
    MemReady = rdy;
    @(negedge clock);
    check(tag, e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic h);
    Halt = h;
    MemReady = 1'($urandom);
    #2 reset_n = 1'b0;
    exp_ret = '0;
    #1 check("reset", v_idle());
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Assumes a fetch is already outstanding on entry.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int fw, input int mw);
    int c;
    c = cls_of(op, f3);
    Opcode = 7'($urandom);
    Funct3 = 3'($urandom);
    for (int i = 0; i < fw; i++) cyc("fetch_wait", v_fetch(1'b0), 1'b0);
    cyc("fetch", v_fetch(1'b1), 1'b1);
    Opcode = op;
    Funct3 = f3;
    cyc("decode", v_decode(), 1'($urandom));
    if (c < 0) begin
      for (int i = 0; i < 10; i++) begin
        Opcode = 7'($urandom);
        cyc("trap", v_trap(), 1'($urandom));
      end
      return;
    end
    cyc("exec", v_exec(c), 1'($urandom));
    if (c >= 3) begin
      for (int i = 0; i < mw; i++) cyc("mem_wait", v_mem(c), 1'b0);
      cyc("mem_done", v_mem(c), 1'b1);
      if (c == 4) exp_ret = exp_ret + 8'd1;
    end
    if (c != 4) begin
      cyc("wb", v_wb(), 1'($urandom));
      exp_ret = exp_ret + 8'd1;
    end
  endtask

  task automatic run_random();
    int c;
    logic [6:0] op;
    logic [2:0] f3;
    c  = $urandom_range(0, 4);
    f3 = 3'($urandom);
    case (c)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0110111;
      3: begin op = 7'b0000011; f3 = 3'b010; end
      default: begin op = 7'b0100011; f3 = 3'b010; end
    endcase
    run_instr(op, f3, $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    reset_n = 1'b0; Halt = 1'b0; MemReady = 1'b0;
    Opcode = '0; Funct3 = '0; exp_ret = '0;
    @(posedge clock);
    #1;

    do_reset(1'b0);
    run_instr(7'b0110011, 3'b000, 0, 0);   // R
    run_instr(7'b0000011, 3'b010, 0, 2);   // LW with two wait cycles
    run_instr(7'b0100011, 3'b010, 0, 0);   // SW
    run_instr(7'b0010011, 3'b101, 1, 0);   // I
    run_instr(7'b0110111, 3'b111, 2, 0);   // LUI

    // Halt raised while a fetch is outstanding is ignored until it completes
    Halt = 1'b1;
    run_instr(7'b0010011, 3'b000, 2, 0);
    cyc("halted", v_idle(), 1'b1);
    cyc("halted", v_idle(), 1'b1);
    Halt = 1'b0;
    cyc("unhalt", v_idle(), 1'b1);
    run_instr(7'b0000011, 3'b010, 1, 1);

    run_instr(7'b1111111, 3'b010, 0, 0);   // illegal opcode
    do_reset(1'b0);
    run_instr(7'b0000011, 3'b000, 0, 0);   // LW with bad funct3
    do_reset(1'b0);
    run_instr(7'b0100011, 3'b000, 1, 0);   // SW with bad funct3
    do_reset(1'b0);

    // Halt held through reset release
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) cyc("halt_idle", v_idle(), 1'($urandom));
    Halt = 1'b0;
    cyc("halt_release", v_idle(), 1'($urandom));
    run_instr(7'b0110011, 3'b000, 0, 0);

    // Asynchronous reset in the middle of a load's memory phase
    Opcode = 7'b0000011; Funct3 = 3'b010;
    cyc("fetch", v_fetch(1'b1), 1'b1);
    cyc("decode", v_decode(), 1'b0);
    cyc("exec", v_exec(3), 1'b0);
    MemReady = 1'b0;
    @(negedge clock);
    check("mem_pre_rst", v_mem(3));
    #2 reset_n = 1'b0;
    exp_ret = '0;
    #1 check("mem_async_rst", v_idle());
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Random legal traffic until the counter reaches all-ones, then wrap
    for (int k = 0; k < 400 && exp_ret != 8'd255; k++) run_random();
    run_instr(7'b0110011, 3'b000, 0, 0);
    n_cmp++;
    assert (Retired === 8'd0) else begin
      n_bad++;
      $error("FAIL wrap: observed %0d expected 0", Retired);
    end
    for (int k = 0; k < 20; k++) run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
